fractal_pixel_scheduler: RTL and testbench
==========================================

Name: fractal_pixel_scheduler

Overview:
- Sequences one frame of fractal compute: walks raster coordinates, dispatches each pixel to one of NUM_UNITS iteration engines in round-robin order, and collects results in the same order.
- Emits an in-order pixel stream with start-of-frame and end-of-line flags, feeding the colour mapper and the stream packer.
- Sits between the AXI-Lite register file (frame size, start, mode) and the compute engines.

Parameters:
- NUM_UNITS, 4, number of iteration engines; valid range 1..16.
- UNIT_W, 4, width of the unit index; must satisfy 2^UNIT_W >= NUM_UNITS.
- RES_W, 8, width of each engine result (iteration count).

Ports:
- out_stream_aclk  in  1  sole clock.
- periph_reset  in  1  synchronous, active-high reset.
- cfg_width  in  10  pixels per line; sampled at frame start.
- cfg_height  in  9  lines per frame; sampled at frame start.
- cfg_continuous  in  1  restart automatically after each frame; sampled at frame start.
- start  in  1  single-cycle request to begin a frame.
- abort  in  1  single-cycle request to stop the current frame.
- busy  out  1  high while state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted downstream.
- unit_req_valid  out  NUM_UNITS  one-hot job offer to engine d_ptr.
- unit_req_ready  in  NUM_UNITS  engine idle and able to take a job.
- unit_req_x  out  10  job x coordinate, shared by all engines.
- unit_req_y  out  9  job y coordinate, shared by all engines.
- unit_res_valid  in  NUM_UNITS  engine holds a finished result.
- unit_res_ready  out  NUM_UNITS  one-hot result accept to engine c_ptr.
- unit_res_data  in  NUM_UNITS*RES_W  results; engine k occupies bits [k*RES_W +: RES_W].
- pix_data  out  RES_W  result for the current output pixel.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  output pixel is (0,0).
- pix_eol  out  1  output pixel is the last in its line.

Behaviour:
- Reset: state IDLE. busy, frame_done, pix_valid, pix_sof and pix_eol are 0. unit_req_valid and unit_res_ready are all 0. d_ptr, c_ptr, pending, all coordinate counters and pix_data are 0.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN: on start with cfg_width != 0 and cfg_height != 0. Latch W, H and CONT, clear all counters and pointers. A start with either dimension 0 is ignored.
- start while busy: ignored.
- Dispatch in RUN:
  - While dispatch is not complete, unit_req_valid[d_ptr] = 1 and unit_req_x/unit_req_y = (dx, dy).
  - A job transfers when unit_req_valid & unit_req_ready on the same edge.
  - On transfer: d_ptr advances, wrapping NUM_UNITS-1 -> 0; dx increments, wrapping W-1 -> 0 with dy+1; pending += 1.
  - After dispatching (W-1, H-1), dispatch is complete and unit_req_valid stays 0.
  - The first job is offered in the cycle after start.
- Collect:
  - unit_res_ready[c_ptr] = (state != IDLE) & (!pix_valid | pix_ready | state == DRAIN).
  - A result transfers when unit_res_valid[c_ptr] & unit_res_ready[c_ptr]. On transfer: c_ptr advances with wrap, pending -= 1.
  - In RUN, the accepted result is registered into pix_data with pix_valid = 1 on the next cycle. pix_sof = (ox==0 & oy==0) and pix_eol = (ox==W-1) are registered alongside, then ox/oy advance.
  - pending never exceeds NUM_UNITS. A simultaneous dispatch and collect leaves pending unchanged.
- Output handshake:
  - pix_valid, pix_data, pix_sof and pix_eol hold stable while pix_valid & !pix_ready.
  - One result per cycle is sustained when pix_ready = 1.
- Frame end: when the pixel with pix_eol & (oy == H-1) is accepted downstream:
  - frame_done pulses for the next cycle.
  - If CONT, re-latch cfg_* and stay in RUN, with the new frame's first job offered in that same cycle.
  - Otherwise go to IDLE.
- abort in RUN:
  - Stop dispatch immediately and go to DRAIN.
  - pix_valid is cleared.
  - In DRAIN, results are accepted and discarded until pending == 0, then go to IDLE.
  - No frame_done is issued. abort in IDLE or DRAIN is ignored.
- Simultaneous start and abort in IDLE: start wins.
- periph_reset mid-frame: immediate return to reset values. Engines are reset by the same signal.
- Coordinates never exceed W-1 / H-1. Pointers never exceed NUM_UNITS-1.

Test Plan:
- Reset, then W=4, H=2, NUM_UNITS=4, engines with 3-cycle latency returning x+8*y, pix_ready=1 -> 8 pixels in order with data 0..3,8..11; sof on the first pixel only; eol on the 4th and 8th; one frame_done pulse; busy drops after it.
- Same frame with pix_ready toggling 1,0,0,1 repeatedly -> no pixel lost or duplicated, outputs stable while stalled, unit_res_ready low while pix_valid & !pix_ready.
- Engines with latencies 1, 7, 2, 5 (units 0..3), W=10, H=1 -> output strictly in raster order, pending ≤ 4, each job goes to unit = index mod 4.
- CONT=1, W=3, H=2, then cfg_width changed to 2 mid-frame -> frame 1 has 6 pixels and frame 2 has 4; frame_done pulses twice; no IDLE cycle between frames.
- abort after 5 jobs dispatched and 2 pixels output -> no further unit_req_valid, remaining 3 results accepted and dropped, then IDLE with no frame_done; a following start runs a clean frame with sof first.
- start with cfg_width=0 -> busy stays 0, no requests; start pulsed while busy -> no effect on counters.

Source files
------------

// File: rtl/fractal_pixel_scheduler.sv
// Frame sequencer for the fractal engines: raster dispatch to NUM_UNITS engines in round-robin
// order, in-order result collection, and a ready/valid pixel stream with SOF/EOL flags.
module fractal_pixel_scheduler #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned UNIT_W    = 4,
    parameter int unsigned RES_W     = 8
) (
    input  logic                         out_stream_aclk,
    input  logic                         periph_reset,
    input  logic [9:0]                   cfg_width,
    input  logic [8:0]                   cfg_height,
    input  logic                         cfg_continuous,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         frame_done,
    output logic [NUM_UNITS-1:0]         unit_req_valid,
    input  logic [NUM_UNITS-1:0]         unit_req_ready,
    output logic [9:0]                   unit_req_x,
    output logic [8:0]                   unit_req_y,
    input  logic [NUM_UNITS-1:0]         unit_res_valid,
    output logic [NUM_UNITS-1:0]         unit_res_ready,
    input  logic [NUM_UNITS*RES_W-1:0]   unit_res_data,
    output logic [RES_W-1:0]             pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic                         pix_sof,
    output logic                         pix_eol
);

    localparam int unsigned PendW = $clog2(NUM_UNITS + 1);
    localparam logic [UNIT_W-1:0] LastUnit = UNIT_W'(NUM_UNITS - 1);
    localparam logic [PendW-1:0] MaxPend = PendW'(NUM_UNITS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e             state_q;
    logic [9:0]         w_q;
    logic [8:0]         h_q;
    logic               cont_q;
    logic [9:0]         dx_q;
    logic [8:0]         dy_q;
    logic               disp_done_q;
    logic [9:0]         ox_q;
    logic [8:0]         oy_q;
    logic [UNIT_W-1:0]  d_ptr_q;
    logic [UNIT_W-1:0]  c_ptr_q;
    logic [PendW-1:0]   pending_q;
    logic [PendW-1:0]   pending_d;
    logic [RES_W-1:0]   pix_data_q;
    logic               pix_valid_q;
    logic               pix_sof_q;
    logic               pix_eol_q;
    logic               pix_last_q;
    logic               frame_done_q;

    logic               req_active;
    logic               req_fire;
    logic               res_open;
    logic               res_fire;
    logic               sel_req_ready;
    logic               sel_res_valid;
    logic [RES_W-1:0]   sel_res_data;
    logic               start_ok;
    logic               relatch_ok;
    logic               frame_end;

    always_comb begin
        sel_req_ready = 1'b0;
        sel_res_valid = 1'b0;
        sel_res_data  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (d_ptr_q == UNIT_W'(k)) begin
                sel_req_ready = unit_req_ready[k];
            end
            if (c_ptr_q == UNIT_W'(k)) begin
                sel_res_valid = unit_res_valid[k];
                sel_res_data  = unit_res_data[k*RES_W +: RES_W];
            end
        end
    end

    always_comb begin
        // Dispatch stalls once every engine holds an uncollected job.
        req_active = (state_q == StRun) && !disp_done_q && !abort && (pending_q != MaxPend);
        req_fire   = req_active && sel_req_ready;
        res_open   = (state_q != StIdle) &&
                     (!pix_valid_q || pix_ready || (state_q == StDrain));
        res_fire   = res_open && sel_res_valid;
        pending_d  = pending_q + PendW'(req_fire) - PendW'(res_fire);
        start_ok   = start && (cfg_width != 10'd0) && (cfg_height != 9'd0);
        relatch_ok = cont_q && (cfg_width != 10'd0) && (cfg_height != 9'd0);
        frame_end  = (state_q == StRun) && pix_valid_q && pix_ready && pix_last_q && !abort;
    end

    always_comb begin
        unit_req_valid = '0;
        unit_res_ready = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            unit_req_valid[k] = req_active && (d_ptr_q == UNIT_W'(k));
            unit_res_ready[k] = res_open && (c_ptr_q == UNIT_W'(k));
        end
    end

    assign unit_req_x = dx_q;
    assign unit_req_y = dy_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_sof    = pix_sof_q;
    assign pix_eol    = pix_eol_q;

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            state_q      <= StIdle;
            w_q          <= '0;
            h_q          <= '0;
            cont_q       <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            disp_done_q  <= 1'b0;
            ox_q         <= '0;
            oy_q         <= '0;
            d_ptr_q      <= '0;
            c_ptr_q      <= '0;
            pending_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            pix_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            pending_q    <= pending_d;

            if (req_fire) begin
                d_ptr_q <= (d_ptr_q == LastUnit) ? '0 : d_ptr_q + UNIT_W'(1);
                if (dx_q == w_q - 10'd1) begin
                    dx_q <= '0;
                    if (dy_q == h_q - 9'd1) begin
                        disp_done_q <= 1'b1;
                    end else begin
                        dy_q <= dy_q + 9'd1;
                    end
                end else begin
                    dx_q <= dx_q + 10'd1;
                end
            end

            if (res_fire) begin
                c_ptr_q <= (c_ptr_q == LastUnit) ? '0 : c_ptr_q + UNIT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q     <= StRun;
                        w_q         <= cfg_width;
                        h_q         <= cfg_height;
                        cont_q      <= cfg_continuous;
                        dx_q        <= '0;
                        dy_q        <= '0;
                        disp_done_q <= 1'b0;
                        ox_q        <= '0;
                        oy_q        <= '0;
                        d_ptr_q     <= '0;
                        c_ptr_q     <= '0;
                        pending_q   <= '0;
                    end
                end
                StRun: begin
                    if (abort) begin
                        // Anything collected from here on is dropped in StDrain.
                        state_q     <= StDrain;
                        pix_valid_q <= 1'b0;
                    end else if (frame_end) begin
                        frame_done_q <= 1'b1;
                        pix_valid_q  <= 1'b0;
                        if (relatch_ok) begin
                            w_q         <= cfg_width;
                            h_q         <= cfg_height;
                            cont_q      <= cfg_continuous;
                            dx_q        <= '0;
                            dy_q        <= '0;
                            disp_done_q <= 1'b0;
                            ox_q        <= '0;
                            oy_q        <= '0;
                            d_ptr_q     <= '0;
                            c_ptr_q     <= '0;
                            pending_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (res_fire) begin
                        pix_data_q  <= sel_res_data;
                        pix_valid_q <= 1'b1;
                        pix_sof_q   <= (ox_q == 10'd0) && (oy_q == 9'd0);
                        pix_eol_q   <= (ox_q == w_q - 10'd1);
                        pix_last_q  <= (ox_q == w_q - 10'd1) && (oy_q == h_q - 9'd1);
                        if (ox_q == w_q - 10'd1) begin
                            ox_q <= '0;
                            oy_q <= (oy_q == h_q - 9'd1) ? '0 : oy_q + 9'd1;
                        end else begin
                            ox_q <= ox_q + 10'd1;
                        end
                    end else if (pix_ready) begin
                        pix_valid_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (pending_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Scoreboard bench: behavioural engines with per-unit latency, expected pixels queued by the
// stimulus, and a negedge monitor that pops and compares every accepted output pixel.
module tb_fractal_pixel_scheduler;

    localparam int NU = 4;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            periph_reset;
    logic [9:0]      cfg_width;
    logic [8:0]      cfg_height;
    logic            cfg_continuous;
    logic            start;
    logic            abort;
    logic            busy;
    logic            frame_done;
    logic [NU-1:0]   unit_req_valid;
    logic [NU-1:0]   unit_req_ready;
    logic [9:0]      unit_req_x;
    logic [8:0]      unit_req_y;
    logic [NU-1:0]   unit_res_valid;
    logic [NU-1:0]   unit_res_ready;
    logic [NU*RW-1:0] unit_res_data;
    logic [RW-1:0]   pix_data;
    logic            pix_valid;
    logic            pix_ready;
    logic            pix_sof;
    logic            pix_eol;

    always #5 clk = ~clk;

    fractal_pixel_scheduler #(
        .NUM_UNITS(NU),
        .UNIT_W   (4),
        .RES_W    (RW)
    ) dut (
        .out_stream_aclk(clk),
        .periph_reset   (periph_reset),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_continuous (cfg_continuous),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .frame_done     (frame_done),
        .unit_req_valid (unit_req_valid),
        .unit_req_ready (unit_req_ready),
        .unit_req_x     (unit_req_x),
        .unit_req_y     (unit_req_y),
        .unit_res_valid (unit_res_valid),
        .unit_res_ready (unit_res_ready),
        .unit_res_data  (unit_res_data),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine models
    int unsigned lat [NU];
    logic        e_busy [NU];
    logic        e_has  [NU];
    int unsigned e_cnt  [NU];
    logic [9:0]  e_x    [NU];
    logic [8:0]  e_y    [NU];
    logic [NU-1:0] s_req;
    logic [NU-1:0] s_res;
    logic [9:0]  s_x;
    logic [8:0]  s_y;

    always_comb begin
        unit_req_ready = '0;
        unit_res_valid = '0;
        unit_res_data  = '0;
        for (int k = 0; k < NU; k++) begin
            unit_req_ready[k] = !e_busy[k] && !e_has[k];
            unit_res_valid[k] = e_has[k];
            unit_res_data[k*RW +: RW] = 8'(e_x[k] + {e_y[k], 3'b000});
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NU; k++) begin
            if (periph_reset) begin
                e_busy[k] <= 1'b0;
                e_has[k]  <= 1'b0;
                e_cnt[k]  <= 0;
                e_x[k]    <= '0;
                e_y[k]    <= '0;
            end else begin
                if (s_res[k]) e_has[k] <= 1'b0;
                if (e_busy[k]) begin
                    if (e_cnt[k] == 0) begin
                        e_busy[k] <= 1'b0;
                        e_has[k]  <= 1'b1;
                    end else begin
                        e_cnt[k] <= e_cnt[k] - 1;
                    end
                end
                if (s_req[k]) begin
                    e_busy[k] <= 1'b1;
                    e_cnt[k]  <= lat[k] - 1;
                    e_x[k]    <= s_x;
                    e_y[k]    <= s_y;
                end
            end
        end
    end

    // Scoreboard and monitor
    logic [9:0] exp_q [$];
    int  jobs_cnt = 0;
    int  outstanding = 0;
    int  done_cnt = 0;
    int  pix_cnt = 0;
    int  cur_w = 1;
    bit  chk_map = 0;
    bit  chk_pend = 0;
    bit  stall_prev = 0;
    logic [9:0] stall_val;
    logic [9:0] got;
    logic [9:0] want;

    task automatic push_frame(input int w, input int h);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                exp_q.push_back({(x == 0 && y == 0), (x == w - 1), 8'(x + 8 * y)});
            end
        end
    endtask

    always @(negedge clk) begin
        s_req = '0;
        s_res = '0;
        if (periph_reset) begin
            stall_prev = 0;
        end else begin
            s_x = unit_req_x;
            s_y = unit_req_y;
            for (int k = 0; k < NU; k++) begin
                s_req[k] = unit_req_valid[k] && unit_req_ready[k];
                s_res[k] = unit_res_valid[k] && unit_res_ready[k];
                if (s_req[k]) begin
                    if (chk_map) begin
                        check("job_unit", k, jobs_cnt % NU);
                        check("job_xy", {s_y, s_x}, {9'(jobs_cnt / cur_w), 10'(jobs_cnt % cur_w)});
                    end
                    jobs_cnt++;
                    outstanding++;
                end
                if (s_res[k]) outstanding--;
            end
            if (chk_pend) check("pending_max", 32'(outstanding <= NU), 1);
            if (frame_done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid", pix_valid, 1);
                check("stall_payload", {pix_sof, pix_eol, pix_data}, stall_val);
            end
            if (pix_valid && !pix_ready) check("stall_res_ready", unit_res_ready, 0);
            stall_prev = pix_valid && !pix_ready;
            stall_val  = {pix_sof, pix_eol, pix_data};
            if (pix_valid && pix_ready) begin
                pix_cnt++;
                got = {pix_sof, pix_eol, pix_data};
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'(got) | 32'h400, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("pixel", got, want);
                end
            end
        end
    end

    // Downstream ready driver
    bit ready_mode = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        int idx = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                pix_ready = pat[idx % 4];
                idx++;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        check("frame_done_seen", seen, 1);
    endtask

    task automatic run_basic(input string tag);
        done_cnt = 0;
        push_frame(4, 2);
        pulse_start();
        wait_done();
        check({tag, "_busy_after"}, busy, 0);
        repeat (4) cyc();
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        bit seen;
        periph_reset   = 1'b1;
        cfg_width      = 10'd4;
        cfg_height     = 9'd2;
        cfg_continuous = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        for (int k = 0; k < NU; k++) lat[k] = 3;
        repeat (3) cyc();
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_sof", pix_sof, 0);
        check("rst_pix_eol", pix_eol, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_req_valid", unit_req_valid, 0);
        check("rst_res_ready", unit_res_ready, 0);
        check("rst_req_xy", {unit_req_y, unit_req_x}, 0);
        periph_reset = 1'b0;
        cyc();

        // Basic 4x2 frame, then with downstream back-pressure
        run_basic("basic");
        ready_mode = 1;
        run_basic("stall");
        ready_mode = 0;
        cyc();

        // Mixed latencies, 10x1
        lat[0] = 1; lat[1] = 7; lat[2] = 2; lat[3] = 5;
        cfg_width = 10'd10;
        cfg_height = 9'd1;
        cur_w = 10;
        jobs_cnt = 0;
        chk_map = 1;
        chk_pend = 1;
        done_cnt = 0;
        push_frame(10, 1);
        pulse_start();
        wait_done();
        repeat (3) cyc();
        chk_map = 0;
        chk_pend = 0;
        check("mixed_jobs", jobs_cnt, 10);
        check("mixed_queue_empty", exp_q.size(), 0);
        check("mixed_done_count", done_cnt, 1);
        for (int k = 0; k < NU; k++) lat[k] = 3;

        // Continuous mode with a width change taking effect on the next frame
        cfg_width = 10'd3;
        cfg_height = 9'd2;
        cfg_continuous = 1'b1;
        done_cnt = 0;
        push_frame(3, 2);
        push_frame(2, 2);
        pulse_start();
        repeat (3) cyc();
        cfg_width = 10'd2;
        cfg_continuous = 1'b0;
        wait_done();
        check("cont_busy_between", busy, 1);
        check("cont_first_job", unit_req_valid, 4'b0001);
        check("cont_first_xy", {unit_req_y, unit_req_x}, 0);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (frame_done) begin
                seen = 1;
                break;
            end
            check("cont_busy_frame2", busy, 1);
        end
        check("cont_second_done", seen, 1);
        check("cont_busy_after", busy, 0);
        repeat (3) cyc();
        check("cont_done_count", done_cnt, 2);
        check("cont_queue_empty", exp_q.size(), 0);

        // Abort after 5 jobs dispatched and 2 pixels delivered
        cfg_width = 10'd4;
        cfg_height = 9'd2;
        done_cnt = 0;
        jobs_cnt = 0;
        pix_cnt = 0;
        exp_q.push_back({1'b1, 1'b0, 8'd0});
        exp_q.push_back({1'b0, 1'b0, 8'd1});
        pulse_start();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (jobs_cnt == 5) begin
                seen = 1;
                break;
            end
            cyc();
        end
        check("abort_reached_5_jobs", seen, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            check("abort_no_req", unit_req_valid, 0);
            if (!busy) begin
                seen = 1;
                break;
            end
            cyc();
        end
        check("abort_idle", seen, 1);
        repeat (3) cyc();
        check("abort_jobs", jobs_cnt, 5);
        check("abort_pixels", pix_cnt, 2);
        check("abort_outstanding", outstanding, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        run_basic("post_abort");

        // Zero width is ignored; start while busy is ignored
        cfg_width = 10'd0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check("zero_busy", busy, 0);
            check("zero_req", unit_req_valid, 0);
            cyc();
        end
        cfg_width = 10'd4;
        done_cnt = 0;
        push_frame(4, 2);
        pulse_start();
        repeat (3) cyc();
        cfg_width = 10'd3;
        pulse_start();
        cfg_width = 10'd4;
        wait_done();
        repeat (4) cyc();
        check("rebusy_done_count", done_cnt, 1);
        check("rebusy_queue_empty", exp_q.size(), 0);
        check("rebusy_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
